// File: rtl/parity_pkg.sv
// parity_pkg: shared states, parity-sense constants and frame length helper
package parity_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD = 1'b1;
  function automatic int frame_len(input int data_w);
    return data_w + 1;
  endfunction
endpackage

// File: rtl/parity_frame_tx_if.sv
// parity_frame_tx_if: data handshake plus parallel and serial frame outputs
interface parity_frame_tx_if import parity_pkg::*; #(
  parameter int DATA_W = 4,
  parameter int CNT_W = 8
);
  logic [DATA_W-1:0] din;
  logic din_valid;
  logic din_ready;
  logic [frame_len(DATA_W)-1:0] frame_q;
  logic frame_vld;
  logic tx_bit;
  logic tx_valid;
  logic tx_last;
  logic [CNT_W-1:0] frame_cnt;
  modport master (
    output din, din_valid,
    input din_ready, frame_q, frame_vld, tx_bit, tx_valid, tx_last, frame_cnt
  );
  modport slave (
    input din, din_valid,
    output din_ready, frame_q, frame_vld, tx_bit, tx_valid, tx_last, frame_cnt
  );
endinterface

// File: rtl/parity_gen.sv
// parity_gen: combinational parity bit, even when ODD=0 and odd when ODD=1
module parity_gen import parity_pkg::*; #(
  parameter int DATA_W = 4,
  parameter bit ODD = PARITY_EVEN
) (
  input  logic [DATA_W-1:0] d,
  output logic p
);
  assign p = ^d ^ ODD;
endmodule

// File: rtl/parity_frame_tx.sv
// parity_frame_tx: frames a nibble with parity, holds it in parallel and shifts it out MSB first
module parity_frame_tx import parity_pkg::*; #(
  parameter int DATA_W = 4,
  parameter bit ODD = PARITY_EVEN,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  parity_frame_tx_if.slave bus
);
  localparam int FL = frame_len(DATA_W);
  localparam int IW = $clog2(FL);
  localparam logic [IW-1:0] LAST = IW'(DATA_W);
  state_t state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [FL-1:0] sr, sr_d, frame_d;
  logic vld_d, p, last, xfer;
  parity_gen #(.DATA_W(DATA_W), .ODD(ODD)) u_par (.d(bus.din), .p(p));
  assign last = state == SHIFT && idx == LAST;
  assign bus.din_ready = state == IDLE || last;
  assign xfer = bus.din_valid && bus.din_ready;
  assign bus.tx_bit = sr[FL-1];
  // a transfer on the parity cycle reloads directly so the line never idles
  always_comb begin
    state_d = state;
    idx_d = idx;
    sr_d = sr;
    frame_d = bus.frame_q;
    vld_d = bus.frame_vld;
    if (xfer) begin
      state_d = SHIFT;
      idx_d = '0;
      sr_d = {bus.din, p};
      frame_d = {bus.din, p};
      vld_d = 1'b1;
    end else if (last) begin
      state_d = IDLE;
      idx_d = '0;
      sr_d = '0;
      vld_d = 1'b0;
    end else if (state == SHIFT) begin
      idx_d = idx + 1'b1;
      sr_d = sr << 1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      sr <= '0;
      bus.frame_q <= '0;
      bus.frame_vld <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_last <= 1'b0;
      bus.frame_cnt <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      sr <= sr_d;
      bus.frame_q <= frame_d;
      bus.frame_vld <= vld_d;
      bus.tx_valid <= state_d == SHIFT;
      bus.tx_last <= state_d == SHIFT && idx_d == LAST;
      bus.frame_cnt <= bus.frame_cnt + CNT_W'(last);
    end
  end
endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx: even and odd instances driven together, checked against a bit-queue scoreboard
module tb_parity_frame_tx;
  typedef logic [1:0] bq_t [$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] din = '0;
  logic din_valid = 1'b0;
  logic ready [2];
  logic fvld [2];
  logic txb [2];
  logic txv [2];
  logic txl [2];
  logic [4:0] fq [2];
  logic [7:0] cnt [2];
  bq_t bq [2];
  logic [4:0] efr [2];
  logic [7:0] ecnt [2];
  bit exp_ready = 1'b1;
  bit run = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    parity_frame_tx_if #(.DATA_W(4), .CNT_W(8)) bus ();
    assign bus.din = din;
    assign bus.din_valid = din_valid;
    parity_frame_tx #(.DATA_W(4), .ODD(g == 1), .CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    assign ready[g] = bus.din_ready;
    assign fvld[g] = bus.frame_vld;
    assign txb[g] = bus.tx_bit;
    assign txv[g] = bus.tx_valid;
    assign txl[g] = bus.tx_last;
    assign fq[g] = bus.frame_q;
    assign cnt[g] = bus.frame_cnt;
  end

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // model: each accepted nibble becomes five {last,bit} entries, consumed one per cycle
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        bq[k].delete();
        efr[k] = '0;
        ecnt[k] = '0;
      end
    end else if (din_valid && exp_ready) begin
      for (int k = 0; k < 2; k++) begin
        automatic logic p = logic'(($countones(din) % 2) != 0) ^ logic'(k == 1);
        efr[k] = {din, p};
        for (int i = 3; i >= 0; i--) bq[k].push_back({1'b0, din[i]});
        bq[k].push_back({1'b1, p});
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      exp_ready = bq[0].size() <= 1;
      for (int k = 0; k < 2; k++) begin
        automatic bit ev = bq[k].size() > 0;
        automatic logic [1:0] e = ev ? bq[k][0] : 2'b00;
        chk("din_ready", k, 8'(ready[k]), 8'(bq[k].size() <= 1));
        chk("tx_valid", k, 8'(txv[k]), 8'(ev));
        chk("tx_last", k, 8'(txl[k]), 8'(e[1]));
        chk("frame_vld", k, 8'(fvld[k]), 8'(ev));
        chk("frame_q", k, 8'(fq[k]), 8'(efr[k]));
        chk("frame_cnt", k, cnt[k], ecnt[k]);
        if (ev) chk("tx_bit", k, 8'(txb[k]), 8'(e[0]));
        if (fvld[k]) begin
          chk("checker_e", k, 8'(^fq[k] ^ logic'(k == 1)), 8'(0));
          chk("checker_flip", k, 8'(^(fq[k] ^ 5'b00010) ^ logic'(k == 1)), 8'(1));
        end
        if (ev) begin
          if (e[1]) ecnt[k] = ecnt[k] + 8'd1;
          void'(bq[k].pop_front());
        end
      end
    end
  end

  task automatic send(input logic [3:0] d, input bit chg);
    bit ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      #1;
      din = chg ? 4'($urandom) : d;
      din_valid = 1'b1;
      ok = exp_ready;
    end
    if (!ok) chk("send_accept", 0, 8'(ok), 8'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      din_valid = 1'b0;
      din = 4'($urandom);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    run = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    send(4'b0110, 1'b0);
    idle(2);
    @(negedge clk);
    #1;
    rst = 1'b1;
    din = 4'b1001;
    din_valid = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    din_valid = 1'b0;
    idle(1);
    send(4'b1011, 1'b0);
    idle(7);
    send(4'b0000, 1'b0);
    idle(7);
    send(4'b1111, 1'b0);
    send(4'b0001, 1'b0);
    idle(7);
    send(4'b0101, 1'b0);
    send(4'b0000, 1'b1);
    idle(7);
    for (int i = 0; i < 16; i++) send(4'(i), 1'b0);
    idle(7);
    for (int n = 0; n < 300; n++) begin
      if ($urandom % 3 == 0) idle(int'($urandom_range(1, 3)));
      send(4'($urandom), ($urandom % 4) == 0);
    end
    idle(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
